reg_itf_arb: RTL and testbench

- Parametrised N-channel register-bus arbiter between host interfaces (SPI slave, I2C slave, on-chip test sequencer, ...) and the single cfg register port (reg_ce/reg_we/reg_addr/reg_wdata/reg_rdata).
- Generalises the fixed one-of-two interface select: any number of hosts may request concurrently.
- Arbitration is round-robin or fixed-priority, with a per-channel bus lock and configurable register read latency.
- Routes read data back to the owning channel only.

---
 rtl/reg_itf_arb.sv | 176 +++++++++++++++++
 tb/tb_reg_itf_arb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_itf_arb.sv
// N-channel register-bus arbiter: picks one host per transaction (lock, fixed or
// round-robin), issues it to the single cfg register port, and returns read data.
module reg_itf_arb #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic                     arb_mode,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH-1:0]        ch_lock,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_gnt,
  output logic [NUM_CH-1:0]        ch_rvld,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [CH_W-1:0]          cur_ch,
  output logic                     busy,
  output logic                     reg_ce,
  output logic                     reg_we,
  output logic [ADDR_W-1:0]        reg_addr,
  output logic [DATA_W-1:0]        reg_wdata,
  input  logic [DATA_W-1:0]        reg_rdata
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]     cur_q, cur_d;
  logic [CH_W-1:0]     lock_ch_q, lock_ch_d;
  logic                lock_vld_q, lock_vld_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ce_q, ce_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NUM_CH-1:0]   gnt_q, gnt_d;
  logic [NUM_CH-1:0]   rvld_q, rvld_d;

  logic                lock_hit;
  logic [CH_W-1:0]     win;
  logic [CH_W:0]       scan;

  // Winner selection; loops run from the lowest-priority candidate so the last hit wins.
  always_comb begin
    lock_hit = lock_vld_q && ch_req[lock_ch_q] && ch_lock[lock_ch_q];
    win      = '0;
    scan     = '0;
    if (lock_hit) begin
      win = lock_ch_q;
    end else if (arb_mode) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (ch_req[CH_W'(i)]) win = CH_W'(i);
      end
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        scan = {1'b0, ptr_q} + (CH_W+1)'(k);
        if (scan >= (CH_W+1)'(NUM_CH)) scan = scan - (CH_W+1)'(NUM_CH);
        if (ch_req[scan[CH_W-1:0]]) win = scan[CH_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cur_d      = cur_q;
    lock_ch_d  = lock_ch_q;
    lock_vld_d = lock_vld_q;
    cnt_d      = cnt_q;
    ce_d       = 1'b0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    gnt_d      = '0;
    rvld_d     = '0;
    case (state_q)
      IDLE: begin
        if (|ch_req) begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (win == CH_W'(i)) begin
              addr_d  = ch_addr[i*ADDR_W +: ADDR_W];
              wdata_d = ch_wdata[i*DATA_W +: DATA_W];
            end
          end
          we_d       = ch_we[win];
          ce_d       = 1'b1;
          gnt_d[win] = 1'b1;
          cur_d      = win;
          ptr_d      = win;
          lock_vld_d = ch_lock[win];
          lock_ch_d  = win;
          state_d    = ISSUE;
        end else begin
          // No requester at all, so the owner cannot be holding its lock.
          lock_vld_d = 1'b0;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d       = reg_rdata;
          rvld_d[cur_q] = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= CH_W'(NUM_CH - 1);
      cur_q      <= '0;
      lock_ch_q  <= '0;
      lock_vld_q <= 1'b0;
      cnt_q      <= '0;
      ce_q       <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      gnt_q      <= '0;
      rvld_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cur_q      <= cur_d;
      lock_ch_q  <= lock_ch_d;
      lock_vld_q <= lock_vld_d;
      cnt_q      <= cnt_d;
      ce_q       <= ce_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      gnt_q      <= gnt_d;
      rvld_q     <= rvld_d;
    end
  end

  assign ch_gnt    = gnt_q;
  assign ch_rvld   = rvld_q;
  assign ch_rdata  = rdata_q;
  assign cur_ch    = cur_q;
  assign busy      = busy_q;
  assign reg_ce    = ce_q;
  assign reg_we    = we_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;

endmodule

// File: tb/tb_reg_itf_arb.sv
// Directed bench for reg_itf_arb: 3 channels, read latency 2, register model with
// a two-stage read pipeline that returns 0xDEAD whenever no read is in flight.
module tb_reg_itf_arb;
  localparam int NCH = 3;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int RL  = 2;

  logic            CLK = 1'b0;
  logic            rst_n = 1'b0;
  logic            arb_mode;
  logic [NCH-1:0]  ch_req, ch_we, ch_lock;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_wdata;
  logic [NCH-1:0]  ch_gnt, ch_rvld;
  logic [DW-1:0]   ch_rdata;
  logic [1:0]      cur_ch;
  logic            busy, reg_ce, reg_we;
  logic [AW-1:0]   reg_addr;
  logic [DW-1:0]   reg_wdata, reg_rdata;
  logic [DW-1:0]   pipe0 = 16'hDEAD, pipe1 = 16'hDEAD;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  int gq_ch[$];
  int gq_cyc[$];

  typedef struct {
    logic [2:0]  req;
    logic        mode;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [2:0]  exp_gnt;
    logic [1:0]  exp_ch;
    logic [7:0]  exp_addr;
    logic [15:0] exp_wdata;
  } vec_t;
  vec_t tbl[8];

  reg_itf_arb #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .CLK(CLK), .rst_n(rst_n), .arb_mode(arb_mode),
    .ch_req(ch_req), .ch_we(ch_we), .ch_lock(ch_lock),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_gnt(ch_gnt), .ch_rvld(ch_rvld), .ch_rdata(ch_rdata),
    .cur_ch(cur_ch), .busy(busy),
    .reg_ce(reg_ce), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] model_rd(input logic [7:0] a);
    return (a == 8'h05) ? 16'h1234 : {8'hA5, a};
  endfunction

  always @(posedge CLK) begin
    pipe0 <= (reg_ce && !reg_we) ? model_rd(reg_addr) : 16'hDEAD;
    pipe1 <= pipe0;
  end
  assign reg_rdata = pipe1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and check bus exclusivity there.
  task automatic cyc();
    @(negedge CLK);
    if (mon_en)
      chk("bus_excl", 32'({$countones(ch_gnt) <= 1, $countones(ch_rvld) <= 1,
                           reg_ce == (|ch_gnt)}), 32'h7);
  endtask

  task automatic drive(input logic [2:0] req, input logic [2:0] we, input logic [2:0] lock,
                       input logic mode, input logic [7:0] a, input logic [15:0] d);
    ch_req   = req;
    ch_we    = we;
    ch_lock  = lock;
    arb_mode = mode;
    for (int i = 0; i < NCH; i++) begin
      ch_addr[i*AW +: AW]  = a + 8'(i);
      ch_wdata[i*DW +: DW] = d + 16'(i);
    end
  endtask

  function automatic int gidx(input logic [2:0] g);
    return g[0] ? 0 : g[1] ? 1 : g[2] ? 2 : -1;
  endfunction

  task automatic record(input int n);
    gq_ch.delete();
    gq_cyc.delete();
    for (int c = 0; c < n; c++) begin
      cyc();
      if (|ch_gnt) begin
        gq_ch.push_back(gidx(ch_gnt));
        gq_cyc.push_back(c);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   32'(ch_gnt),    32'h0);
    chk({tag, "_rvld"},  32'(ch_rvld),   32'h0);
    chk({tag, "_rdata"}, 32'(ch_rdata),  32'h0);
    chk({tag, "_cur"},   32'(cur_ch),    32'h0);
    chk({tag, "_busy"},  32'(busy),      32'h0);
    chk({tag, "_ce"},    32'(reg_ce),    32'h0);
    chk({tag, "_we"},    32'(reg_we),    32'h0);
    chk({tag, "_addr"},  32'(reg_addr),  32'h0);
    chk({tag, "_wdata"}, 32'(reg_wdata), 32'h0);
  endtask

  initial begin
    // Write vectors applied in order from reset (RR pointer starts at 2).
    tbl[0] = '{3'b001, 1'b0, 8'h12, 16'hBEEF, 3'b001, 2'd0, 8'h12, 16'hBEEF};
    tbl[1] = '{3'b010, 1'b0, 8'h20, 16'h1000, 3'b010, 2'd1, 8'h21, 16'h1001};
    tbl[2] = '{3'b111, 1'b1, 8'h30, 16'h2000, 3'b001, 2'd0, 8'h30, 16'h2000};
    tbl[3] = '{3'b110, 1'b1, 8'h40, 16'h3000, 3'b010, 2'd1, 8'h41, 16'h3001};
    tbl[4] = '{3'b101, 1'b0, 8'h50, 16'h4000, 3'b100, 2'd2, 8'h52, 16'h4002};
    tbl[5] = '{3'b011, 1'b0, 8'h60, 16'h5000, 3'b001, 2'd0, 8'h60, 16'h5000};
    tbl[6] = '{3'b111, 1'b0, 8'h70, 16'h6000, 3'b010, 2'd1, 8'h71, 16'h6001};
    tbl[7] = '{3'b100, 1'b1, 8'h80, 16'h7000, 3'b100, 2'd2, 8'h82, 16'h7002};

    drive(3'b000, 3'b000, 3'b000, 1'b0, 8'h00, 16'h0000);
    repeat (2) @(posedge CLK);
    cyc();
    chk_all_zero("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int v = 0; v < 8; v++) begin
      @(posedge CLK); #1;
      drive(tbl[v].req, 3'b111, 3'b000, tbl[v].mode, tbl[v].addr, tbl[v].wdata);
      cyc();
      @(posedge CLK); #1;
      drive(3'b000, 3'b111, 3'b000, tbl[v].mode, tbl[v].addr, tbl[v].wdata);
      cyc();
      chk($sformatf("v%0d_gnt", v),   32'(ch_gnt),    32'(tbl[v].exp_gnt));
      chk($sformatf("v%0d_ce", v),    32'(reg_ce),    32'h1);
      chk($sformatf("v%0d_we", v),    32'(reg_we),    32'h1);
      chk($sformatf("v%0d_addr", v),  32'(reg_addr),  32'(tbl[v].exp_addr));
      chk($sformatf("v%0d_wdata", v), 32'(reg_wdata), 32'(tbl[v].exp_wdata));
      chk($sformatf("v%0d_cur", v),   32'(cur_ch),    32'(tbl[v].exp_ch));
      chk($sformatf("v%0d_busy", v),  32'(busy),      32'h1);
      cyc();
      chk($sformatf("v%0d_idle", v),  32'({busy, reg_ce, ch_gnt}), 32'h0);
    end

    // Read from ch1, address 0x05, two-cycle register latency.
    @(posedge CLK); #1;
    drive(3'b010, 3'b000, 3'b000, 1'b0, 8'h04, 16'h0000);
    cyc();
    @(posedge CLK); #1;
    drive(3'b000, 3'b000, 3'b000, 1'b0, 8'h04, 16'h0000);
    cyc();
    chk("rd_gnt",  32'(ch_gnt),   32'h2);
    chk("rd_ce",   32'(reg_ce),   32'h1);
    chk("rd_we",   32'(reg_we),   32'h0);
    chk("rd_addr", 32'(reg_addr), 32'h05);
    cyc();
    chk("rd_t2", 32'({ch_rvld, reg_ce, busy}), 32'h1);
    cyc();
    chk("rd_t3", 32'({ch_rvld, reg_ce, busy}), 32'h1);
    cyc();
    chk("rd_rvld",  32'(ch_rvld),  32'h2);
    chk("rd_rdata", 32'(ch_rdata), 32'h1234);
    cyc();
    chk("rd_t5",   32'({ch_rvld, busy}), 32'h0);
    chk("rd_hold", 32'(ch_rdata),        32'h1234);

    // Reset pulse so round-robin starts again from ch0.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("pulse_cur", 32'(cur_ch), 32'h0);

    @(posedge CLK); #1;
    drive(3'b111, 3'b111, 3'b000, 1'b0, 8'hA0, 16'hC000);
    record(12);
    chk("rr_count", 32'(gq_ch.size()), 32'd6);
    for (int k = 0; k < gq_ch.size(); k++) begin
      chk($sformatf("rr_order%0d", k), 32'(gq_ch[k]), 32'(k % 3));
      if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(gq_cyc[k] - gq_cyc[k-1]), 32'd2);
    end

    arb_mode = 1'b1;
    record(6);
    chk("fix_count", 32'(gq_ch.size()), 32'd3);
    for (int k = 0; k < gq_ch.size(); k++)
      chk($sformatf("fix_order%0d", k), 32'(gq_ch[k]), 32'd0);

    drive(3'b000, 3'b111, 3'b000, 1'b0, 8'hA0, 16'hC000);
    repeat (2) @(posedge CLK);
    #1;
    // RR pointer now at 0, so ch1 wins first and its lock then holds the bus.
    drive(3'b011, 3'b111, 3'b010, 1'b0, 8'hB0, 16'hD000);
    record(8);
    chk("lock_count", 32'(gq_ch.size()), 32'd4);
    for (int k = 0; k < gq_ch.size(); k++)
      chk($sformatf("lock_order%0d", k), 32'(gq_ch[k]), 32'd1);
    ch_lock = 3'b000;
    record(2);
    chk("unlock_count", 32'(gq_ch.size()), 32'd1);
    if (gq_ch.size() > 0) chk("unlock_ch", 32'(gq_ch[0]), 32'd0);
    ch_req = 3'b000;
    repeat (3) cyc();

    // Reset during the WAIT phase of a ch1 read.
    @(posedge CLK); #1;
    drive(3'b010, 3'b000, 3'b000, 1'b0, 8'h04, 16'h0000);
    cyc();
    @(posedge CLK); #1;
    ch_req = 3'b000;
    cyc();
    chk("mr_issue", 32'(ch_gnt), 32'h2);
    cyc();
    chk("mr_wait_busy", 32'({busy, reg_ce}), 32'h2);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++)
      chk($sformatf("mr_quiet%0d", c), 32'({ch_rvld, busy, reg_ce}), 32'h0);
    // The loop above samples without advancing; step through the quiet window now.
    for (int c = 0; c < 6; c++) begin
      cyc();
      chk($sformatf("mr_norvld%0d", c), 32'({ch_rvld, busy}), 32'h0);
    end
    @(posedge CLK); #1;
    drive(3'b111, 3'b111, 3'b000, 1'b0, 8'h90, 16'h8000);
    cyc();
    @(posedge CLK); #1;
    ch_req = 3'b000;
    cyc();
    chk("mr_first_gnt", 32'(ch_gnt),   32'h1);
    chk("mr_first_cur", 32'(cur_ch),   32'h0);
    chk("mr_first_adr", 32'(reg_addr), 32'h90);
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
